pipe_ctrl_unit: RTL and testbench

Pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and RAW hazards (stall), handles jump/branch flushes, and generates EX-stage operand-forwarding selects. It sits between the IF/ID register and the datapath and replaces the single-cycle combinational decoder.

---
 rtl/pipe_ctrl_pkg.sv | 79 +++++++
 rtl/pipe_ctrl_unit_decode.sv | 74 +++++++
 rtl/pipe_ctrl_unit.sv | 116 +++++++++++
 tb/tb_pipe_ctrl_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, the per-stage control bundle and small hazard helpers
// for the pipelined MIPS control unit.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    // I-type arithmetic is the whole 001xxx opcode group
    localparam logic [2:0] OP_IARITH_HI = 3'b001;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JAL  = 2'b10;
    localparam logic [1:0] JUMP_JR   = 2'b11;

    localparam logic [1:0] BRANCH_NONE = 2'b00;
    localparam logic [1:0] BRANCH_BEQ  = 2'b01;
    localparam logic [1:0] BRANCH_BNE  = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNC  = 2'b10;
    localparam logic [1:0] ALUOP_IARITH = 2'b11;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    localparam logic [REG_AW-1:0] REG_LINK = 5'd31;

    // Control bundle carried through ID/EX, EX/MEM and MEM/WB.
    // An all-zero value is a bubble.
    typedef struct packed {
        logic              regdst;
        logic              alusrc;
        logic [1:0]        aluop;
        logic [1:0]        branch;
        logic              mem_read;
        logic              mem_write;
        logic              regwrite;
        logic              memtoreg;
        logic              link;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
    } ctrl_t;

    // True when a later-stage instruction writes a register the ID
    // instruction actually reads.
    function automatic logic src_hit(input ctrl_t stg, input logic use_rs,
                                     input logic use_rt,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt);
        return stg.regwrite && (stg.dst != '0) &&
               ((use_rs && (stg.dst == rs)) || (use_rt && (stg.dst == rt)));
    endfunction

    // EX operand select: the younger producer (EX/MEM) wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input ctrl_t mem, input ctrl_t wb,
                                           input logic [REG_AW-1:0] src);
        if (mem.regwrite && (mem.dst != '0) && (mem.dst == src))
            return FWD_EXMEM;
        else if (wb.regwrite && (wb.dst != '0) && (wb.dst == src))
            return FWD_MEMWB;
        else
            return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: instruction word to control bundle,
// source-register usage flags and jump kind.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    output ctrl_t       ctrl_o,
    output logic        use_rs_o,
    output logic        use_rt_o,
    output logic [1:0]  jump_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_nop;
    logic       is_r, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_iar;

    // Classify the opcode, then build the bundle; a NOP leaves everything zero.
    always_comb begin
        op     = instr_i[31:26];
        funct  = instr_i[5:0];
        is_nop = !valid_i || (instr_i == 32'd0);
        is_r   = !is_nop && (op == OP_RTYPE);
        is_jr  = is_r && (funct == FUNCT_JR);
        is_j   = !is_nop && (op == OP_J);
        is_jal = !is_nop && (op == OP_JAL);
        is_beq = !is_nop && (op == OP_BEQ);
        is_bne = !is_nop && (op == OP_BNE);
        is_lw  = !is_nop && (op == OP_LW);
        is_sw  = !is_nop && (op == OP_SW);
        is_iar = !is_nop && (op[5:3] == OP_IARITH_HI);

        ctrl_o   = '0;
        use_rs_o = 1'b0;
        use_rt_o = 1'b0;
        jump_o   = JUMP_NONE;

        if (!is_nop) begin
            ctrl_o.rs        = instr_i[25:21];
            ctrl_o.rt        = instr_i[20:16];
            ctrl_o.regdst    = is_r;
            ctrl_o.alusrc    = is_iar | is_lw | is_sw;
            ctrl_o.mem_read  = is_lw;
            ctrl_o.memtoreg  = is_lw;
            ctrl_o.mem_write = is_sw;
            ctrl_o.link      = is_jal;

            if (is_r)                 ctrl_o.aluop = ALUOP_RFUNC;
            else if (is_iar)          ctrl_o.aluop = ALUOP_IARITH;
            else if (is_beq | is_bne) ctrl_o.aluop = ALUOP_SUB;
            else                      ctrl_o.aluop = ALUOP_ADD;

            if (is_beq)      ctrl_o.branch = BRANCH_BEQ;
            else if (is_bne) ctrl_o.branch = BRANCH_BNE;

            if (is_r)                 ctrl_o.dst = instr_i[15:11];
            else if (is_iar | is_lw)  ctrl_o.dst = instr_i[20:16];
            else if (is_jal)          ctrl_o.dst = REG_LINK;

            // Writing r0 is a no-op, so it never counts as a producer.
            ctrl_o.regwrite = ((is_r && !is_jr) | is_iar | is_lw | is_jal) &&
                              (ctrl_o.dst != '0);

            use_rs_o = is_r | is_iar | is_lw | is_sw | is_beq | is_bne;
            use_rt_o = (is_r && !is_jr) | is_sw | is_beq | is_bne;

            if (is_j)        jump_o = JUMP_J;
            else if (is_jal) jump_o = JUMP_JAL;
            else if (is_jr)  jump_o = JUMP_JR;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the IF/ID instruction, carries controls
// through ID/EX, EX/MEM and MEM/WB, and produces stall, flush and EX
// operand-forwarding selects.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int RA_W       = 5
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     id_instr,
    input  logic            id_valid,
    input  logic            ex_br_taken,
    output logic            pc_hold,
    output logic            ifid_flush,
    output logic [1:0]      id_jump,
    output logic            ex_regdst,
    output logic            ex_alusrc,
    output logic [1:0]      ex_aluop,
    output logic [1:0]      ex_branch,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b,
    output logic            mem_read,
    output logic            mem_write,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic            wb_link,
    output logic [RA_W-1:0] wb_dst
);

    ctrl_t      dec_ctrl;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic [1:0] dec_jump;

    ctrl_t idex_q,  idex_d;
    ctrl_t exmem_q, exmem_d;
    ctrl_t memwb_q, memwb_d;

    logic ld_use, raw_hz, jr_wait, stall, br_flush;

    ctrl_decode u_decode (
        .instr_i  (id_instr),
        .valid_i  (id_valid),
        .ctrl_o   (dec_ctrl),
        .use_rs_o (dec_use_rs),
        .use_rt_o (dec_use_rt),
        .jump_o   (dec_jump)
    );

    // Hazard detection and next-state of the three stage registers.
    always_comb begin
        ld_use = idex_q.mem_read &&
                 src_hit(idex_q, dec_use_rs, dec_use_rt, dec_ctrl.rs, dec_ctrl.rt);
        raw_hz = src_hit(idex_q,  dec_use_rs, dec_use_rt, dec_ctrl.rs, dec_ctrl.rt) ||
                 src_hit(exmem_q, dec_use_rs, dec_use_rt, dec_ctrl.rs, dec_ctrl.rt);
        // JR resolves in ID, where nothing is forwarded, so it waits for
        // any EX/MEM producer of rs regardless of the forwarding mode.
        jr_wait = (dec_jump == JUMP_JR) &&
                  (src_hit(idex_q,  1'b1, 1'b0, dec_ctrl.rs, dec_ctrl.rt) ||
                   src_hit(exmem_q, 1'b1, 1'b0, dec_ctrl.rs, dec_ctrl.rt));
        stall    = ((FORWARDING != 0) ? ld_use : raw_hz) || jr_wait;
        br_flush = ex_br_taken && (idex_q.branch != BRANCH_NONE);

        // A taken branch discards the ID instruction, so it overrides both
        // the stall and any jump decoded there.
        pc_hold    = stall && !br_flush;
        ifid_flush = br_flush || (!stall && (dec_jump != JUMP_NONE));
        id_jump    = (stall || br_flush) ? JUMP_NONE : dec_jump;

        idex_d  = (stall || br_flush) ? ctrl_t'('0) : dec_ctrl;
        exmem_d = idex_q;
        memwb_d = exmem_q;
    end

    // EX operand forwarding selects.
    always_comb begin
        ex_fwd_a = FWD_REGFILE;
        ex_fwd_b = FWD_REGFILE;
        if (FORWARDING != 0) begin
            ex_fwd_a = fwd_sel(exmem_q, memwb_q, idex_q.rs);
            ex_fwd_b = fwd_sel(exmem_q, memwb_q, idex_q.rt);
        end
    end

    // Stage registers; reset loads bubbles everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_regdst   = idex_q.regdst;
    assign ex_alusrc   = idex_q.alusrc;
    assign ex_aluop    = idex_q.aluop;
    assign ex_branch   = idex_q.branch;
    assign mem_read    = exmem_q.mem_read;
    assign mem_write   = exmem_q.mem_write;
    assign wb_regwrite = memwb_q.regwrite;
    assign wb_memtoreg = memwb_q.memtoreg;
    assign wb_link     = memwb_q.link;
    assign wb_dst      = RA_W'(memwb_q.dst);

    // Only part of the WB bundle drives outputs; the rest is carried along.
    logic unused_memwb;
    assign unused_memwb = ^memwb_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with forwarding, one
// without, sharing clock, reset and ID-stage inputs.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] O_LW  = 6'b100011;
    localparam logic [5:0] O_BEQ = 6'b000100;
    localparam logic [5:0] O_JAL = 6'b000011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_br_taken;

    int ncmp  = 0;
    int nfail = 0;

    // Outputs of the FORWARDING=1 instance (suffix 1) and FORWARDING=0 (suffix 0)
    logic       ph1, fl1, rd1, as1, mr1, mw1, wr1, wm1, wl1;
    logic [1:0] jp1, ao1, br1, fa1, fb1;
    logic [4:0] wd1;
    logic       ph0, fl0, rd0, as0, mr0, mw0, wr0, wm0, wl0;
    logic [1:0] jp0, ao0, br0, fa0, fb0;
    logic [4:0] wd0;
    logic [23:0] all1, all0;

    assign all1 = {ph1, fl1, jp1, rd1, as1, ao1, br1, fa1, fb1, mr1, mw1, wr1, wm1, wl1, wd1};
    assign all0 = {ph0, fl0, jp0, rd0, as0, ao0, br0, fa0, fb0, mr0, mw0, wr0, wm0, wl0, wd0};

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.FORWARDING(1), .RA_W(5)) u_fwd (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_br_taken(ex_br_taken), .pc_hold(ph1), .ifid_flush(fl1), .id_jump(jp1),
        .ex_regdst(rd1), .ex_alusrc(as1), .ex_aluop(ao1), .ex_branch(br1),
        .ex_fwd_a(fa1), .ex_fwd_b(fb1), .mem_read(mr1), .mem_write(mw1),
        .wb_regwrite(wr1), .wb_memtoreg(wm1), .wb_link(wl1), .wb_dst(wd1)
    );

    pipe_ctrl_unit #(.FORWARDING(0), .RA_W(5)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_br_taken(ex_br_taken), .pc_hold(ph0), .ifid_flush(fl0), .id_jump(jp0),
        .ex_regdst(rd0), .ex_alusrc(as0), .ex_aluop(ao0), .ex_branch(br0),
        .ex_fwd_a(fa0), .ex_fwd_b(fb0), .mem_read(mr0), .mem_write(mw0),
        .wb_regwrite(wr0), .wb_memtoreg(wm0), .wb_link(wl0), .wb_dst(wd0)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] ins, input logic v, input logic br);
        id_instr    = ins;
        id_valid    = v;
        ex_br_taken = br;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(32'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_instr = 32'd0;
        id_valid = 1'b0;
        ex_br_taken = 1'b0;
        #2;
        chk("reset_all_fwd",   32'(all1), 0);
        chk("reset_all_nofwd", 32'(all0), 0);
        step();
        rst_n = 1'b1;
        #1;

        // add r3,r1,r2 ; sub r4,r3,r1 with forwarding
        do_reset();
        set_in(rtype(5'd1, 5'd2, 5'd3, F_ADD), 1'b1, 1'b0);
        chk("t1_add_hold", 32'(ph1), 0);
        step();
        set_in(rtype(5'd3, 5'd1, 5'd4, F_SUB), 1'b1, 1'b0);
        chk("t1_sub_hold", 32'(ph1), 0);
        chk("t1_add_aluop", 32'(ao1), 2);
        chk("t1_add_regdst", 32'(rd1), 1);
        chk("t1_add_fwda", 32'(fa1), 0);
        step();
        set_in(32'd0, 1'b0, 1'b0);
        chk("t1_sub_fwda", 32'(fa1), 2);
        chk("t1_sub_fwdb", 32'(fb1), 0);
        step();
        chk("t1_add_wb_rw", 32'(wr1), 1);
        chk("t1_add_wb_dst", 32'(wd1), 3);

        // lw r5,0(r1) ; add r6,r5,r2 -- one load-use stall
        do_reset();
        set_in(itype(O_LW, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
        chk("t2_lw_hold", 32'(ph1), 0);
        step();
        set_in(rtype(5'd5, 5'd2, 5'd6, F_ADD), 1'b1, 1'b0);
        chk("t2_ld_use_hold", 32'(ph1), 1);
        chk("t2_ld_use_flush", 32'(fl1), 0);
        chk("t2_lw_alusrc", 32'(as1), 1);
        step();
        chk("t2_after_stall_hold", 32'(ph1), 0);
        chk("t2_bubble_alusrc", 32'(as1), 0);
        chk("t2_bubble_regdst", 32'(rd1), 0);
        chk("t2_lw_mem_read", 32'(mr1), 1);
        step();
        set_in(32'd0, 1'b0, 1'b0);
        chk("t2_add_fwda", 32'(fa1), 1);
        chk("t2_add_fwdb", 32'(fb1), 0);
        chk("t2_add_regdst", 32'(rd1), 1);
        chk("t2_lw_wb_memtoreg", 32'(wm1), 1);
        chk("t2_lw_wb_dst", 32'(wd1), 5);

        // add r3,r1,r2 ; or r7,r3,r0 without forwarding -- two-cycle stall
        do_reset();
        set_in(rtype(5'd1, 5'd2, 5'd3, F_ADD), 1'b1, 1'b0);
        chk("t3_add_hold", 32'(ph0), 0);
        step();
        set_in(rtype(5'd3, 5'd0, 5'd7, F_OR), 1'b1, 1'b0);
        chk("t3_raw_ex_hold", 32'(ph0), 1);
        chk("t3_fwd_no_hold", 32'(ph1), 0);
        chk("t3_fwda_c1", 32'(fa0), 0);
        chk("t3_fwdb_c1", 32'(fb0), 0);
        step();
        chk("t3_raw_mem_hold", 32'(ph0), 1);
        chk("t3_bubble_regdst", 32'(rd0), 0);
        chk("t3_fwda_c2", 32'(fa0), 0);
        step();
        chk("t3_release_hold", 32'(ph0), 0);
        step();
        set_in(32'd0, 1'b0, 1'b0);
        chk("t3_or_regdst", 32'(rd0), 1);
        chk("t3_or_fwda", 32'(fa0), 0);
        chk("t3_or_fwdb", 32'(fb0), 0);

        // jal: one-cycle flush, link write three cycles later
        do_reset();
        set_in({O_JAL, 26'h0000040}, 1'b1, 1'b0);
        chk("t4_jal_jump", 32'(jp1), 2);
        chk("t4_jal_flush", 32'(fl1), 1);
        chk("t4_jal_hold", 32'(ph1), 0);
        step();
        set_in(32'd0, 1'b0, 1'b0);
        chk("t4_after_jump", 32'(jp1), 0);
        chk("t4_after_flush", 32'(fl1), 0);
        step();
        step();
        chk("t4_wb_regwrite", 32'(wr1), 1);
        chk("t4_wb_link", 32'(wl1), 1);
        chk("t4_wb_dst", 32'(wd1), 31);

        // lw r5 ; beq r1,r2 ; add r6,r5,r2 with the branch taken in EX
        do_reset();
        set_in(itype(O_LW, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
        step();
        set_in(itype(O_BEQ, 5'd1, 5'd2, 16'd4), 1'b1, 1'b0);
        chk("t5_beq_hold_nofwd", 32'(ph0), 0);
        step();
        set_in(rtype(5'd5, 5'd2, 5'd6, F_ADD), 1'b1, 1'b1);
        chk("t5_ex_branch", 32'(br0), 1);
        chk("t5_ex_aluop", 32'(ao0), 1);
        chk("t5_br_flush_nofwd", 32'(fl0), 1);
        chk("t5_br_hold_nofwd", 32'(ph0), 0);
        chk("t5_br_flush_fwd", 32'(fl1), 1);
        chk("t5_br_hold_fwd", 32'(ph1), 0);
        step();
        set_in(32'd0, 1'b0, 1'b0);
        chk("t5_bubble_regdst_fwd", 32'(rd1), 0);
        chk("t5_bubble_aluop_fwd", 32'(ao1), 0);
        chk("t5_bubble_branch_nofwd", 32'(br0), 0);

        // add r8,r1,r2 ; jr r8 -- JR waits for the EX and MEM producer
        do_reset();
        set_in(rtype(5'd1, 5'd2, 5'd8, F_ADD), 1'b1, 1'b0);
        step();
        set_in(rtype(5'd8, 5'd0, 5'd0, F_JR), 1'b1, 1'b0);
        chk("t6_jr_hold_ex", 32'(ph1), 1);
        chk("t6_jr_jump_held", 32'(jp1), 0);
        chk("t6_jr_flush_held", 32'(fl1), 0);
        step();
        chk("t6_jr_hold_mem", 32'(ph1), 1);
        step();
        chk("t6_jr_release", 32'(ph1), 0);
        chk("t6_jr_jump", 32'(jp1), 3);
        chk("t6_jr_flush", 32'(fl1), 1);

        // asynchronous reset with lw in MEM
        do_reset();
        set_in(itype(O_LW, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
        step();
        set_in(rtype(5'd5, 5'd2, 5'd6, F_ADD), 1'b1, 1'b0);
        chk("t7_stall_hold", 32'(ph1), 1);
        step();
        chk("t7_lw_mem_read", 32'(mr1), 1);
        set_in(itype(O_LW, 5'd1, 5'd5, 16'd0), 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t7_async_mem_read", 32'(mr1), 0);
        chk("t7_async_all_fwd", 32'(all1), 0);
        chk("t7_async_all_nofwd", 32'(all0), 0);
        step();
        chk("t7_in_reset_all", 32'(all1), 0);
        rst_n = 1'b1;
        #1;
        chk("t7_release_all", 32'(all1), 0);
        step();
        chk("t7_new_lw_alusrc", 32'(as1), 1);
        chk("t7_new_mem_read", 32'(mr1), 0);
        chk("t7_new_wb_rw", 32'(wr1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
